// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: serializer state encoding,
// parity mode constants and a parity helper.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ser_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Widest legal frame payload; narrower words are zero-extended by the caller.
  localparam int MAX_DATA_W = 9;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake bundle for the UART transmit FIFO.
// Ports: tx_valid/tx_data/flush from producer, tx_ready back from the FIFO.
// master = producer, slave = FIFO.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
) ();

  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              flush;

  modport master (output tx_valid, output tx_data, output flush, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input flush, output tx_ready);

endinterface

// File: rtl/uart_tx_ser.sv
// UART frame serializer: start, DATA_W bits LSB first, optional parity, stop.
// Latency: word popped in cycle N appears as start bit on txd from cycle N+1.
// Backpressure: pop_rdy only in IDLE or the last stop-bit cycle, so frames run back to back.
// Ports: clk/rst, pop_vld/pop_dat/pop_rdy from the FIFO, registered txd, busy.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CLK_PER_BIT = 868,
  parameter int PARITY      = PARITY_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pop_vld,
  input  logic [DATA_W-1:0] pop_dat,
  output logic              pop_rdy,
  output logic              txd,
  output logic              busy
);

  // The counter must hold the longest load, which is the full stop period.
  localparam int CNT_W = $clog2(STOP_BITS * CLK_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS * CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

  ser_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              txd_q, txd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pop_rdy = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        pop_rdy = 1'b1;
        if (pop_vld) begin
          state_d = ST_START;
          data_d  = pop_dat;
          cnt_d   = BIT_LOAD;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          bit_d   = '0;
          cnt_d   = BIT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LOAD;
          if (bit_q == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PARITY;
            end else begin
              state_d = ST_STOP;
              cnt_d   = STOP_LOAD;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (cnt_q == '0) begin
          state_d = ST_STOP;
          cnt_d   = STOP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          // Last stop cycle: take the next word now so no idle gap appears.
          pop_rdy = 1'b1;
          if (pop_vld) begin
            state_d = ST_START;
            data_d  = pop_dat;
            cnt_d   = BIT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // txd is decoded from the next state so the line register changes in step with it.
    txd_d = 1'b1;
    unique case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = data_d[bit_d];
      ST_PARITY: txd_d = parity_bit(MAX_DATA_W'(data_d), PARITY);
      default:   txd_d = 1'b1;
    endcase
  end

  assign txd  = txd_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a DEPTH-entry word FIFO in front of the serializer.
// Latency: push in cycle N into an empty, idle block drives the start bit from cycle N+2.
// Backpressure: tx_ready drops when DEPTH words are queued; pushes while not ready set overflow.
// Ports: clk/rst, tx_if (slave: tx_valid/tx_data/flush in, tx_ready out), txd, busy, count, overflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int CLK_PER_BIT = 868,
  parameter int PARITY      = PARITY_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_fifo_if.slave          tx_if,
  output logic                   txd,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  // One extra pointer bit distinguishes full from empty.
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              ready, empty, push, pop, pop_vld, pop_rdy, ser_busy;

  assign ready = (count_q != PTR_W'(DEPTH));
  assign empty = (wr_ptr_q == rd_ptr_q);
  // flush drops a same-cycle push and holds off a same-cycle pop.
  assign push    = tx_if.tx_valid && ready && !tx_if.flush;
  assign pop_vld = !empty && !tx_if.flush;
  assign pop     = pop_vld && pop_rdy;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (tx_if.tx_valid && !ready);
    if (tx_if.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + PTR_W'(1);
        2'b01:   count_d = count_q - PTR_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[IDX_W-1:0]] <= tx_if.tx_data;
  end

  uart_tx_ser #(
    .DATA_W      (DATA_W),
    .CLK_PER_BIT (CLK_PER_BIT),
    .PARITY      (PARITY),
    .STOP_BITS   (STOP_BITS)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .pop_vld (pop_vld),
    .pop_dat (mem[rd_ptr_q[IDX_W-1:0]]),
    .pop_rdy (pop_rdy),
    .txd     (txd),
    .busy    (ser_busy)
  );

  assign tx_if.tx_ready = ready;
  assign busy           = ser_busy || (count_q != '0);
  assign count          = count_q;
  assign overflow       = overflow_q;

endmodule
